int_ctrl_vec: RTL
=================

Name: int_ctrl_vec

Overview:
- Parametrised vectored interrupt controller that replaces the fixed 8-line raw interrupt input on the CPU.
- Synchronises N external interrupt lines and latches rising edges as pending.
- Applies a per-channel mask and fixed priority (channel 0 highest), then presents one vector to the CPU over a request/acknowledge handshake.
- Tracks in-service channels until the CPU executes a return-from-interrupt.

Parameters:
- N_IRQ, 8, number of interrupt channels (1..16)
- VEC_W, 8, width of the vector output (call target address)
- VEC_BASE, 8'h10, vector of channel 0
- VEC_STRIDE, 4, address distance between consecutive channel vectors
- SYNC_STAGES, 2, synchroniser depth on irq_in (2..3)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- irq_in  in  N_IRQ  raw external interrupt lines
- mask_we  in  1  write-enable for the mask register
- mask_din  in  N_IRQ  new mask value; 1 = channel enabled
- pend_clr  in  N_IRQ  one-cycle software clear of pending bits
- irq_ack  in  1  CPU takes the interrupt (the cycle it performs the vectored call)
- irq_ret  in  1  CPU executes return-from-interrupt
- irq_req  out  1  interrupt request to the CPU
- irq_vec  out  VEC_W  call target for the granted channel
- pend_out  out  N_IRQ  pending register
- isr_out  out  N_IRQ  in-service register
- mask_out  out  N_IRQ  mask register

Behaviour:
- Reset values: sync chain, edge history, pend, isr, mask, irq_req, irq_vec and the latched channel index are all 0. The FSM is in IDLE. Reset asserted mid-handshake aborts the handshake immediately.
- Edge detect:
  - pend[i] is set on a 0->1 transition of the synchronised line.
  - Latency is fixed: irq_in high sampled at edge k -> pend set at edge k+SYNC_STAGES -> irq_req high after edge k+SYNC_STAGES+1 (if eligible and idle).
- Eligibility:
  - Channel i is eligible when pend[i] & mask[i] and i is numerically lower than every set isr bit (or isr == 0).
  - The winner is the lowest eligible index.
- FSM IDLE:
  - Stays in IDLE while no channel is eligible.
  - Otherwise latches winner index w, drives irq_vec = VEC_BASE + w*VEC_STRIDE (truncated to VEC_W), sets irq_req = 1 and moves to REQ.
- FSM REQ:
  - irq_req and irq_vec are held stable. Later higher-priority arrivals, mask writes and pend_clr do not change them.
  - On irq_ack: clear pend[w], set isr[w], drop irq_req, return to IDLE.
  - A new re-evaluation happens no earlier than the next cycle, giving at least one idle cycle between requests.
- Clearing the latched channel during REQ: if pend_clr[w] occurs while in REQ, the request is withdrawn. irq_req drops next cycle and the FSM returns to IDLE with no isr change.
- irq_ack in IDLE: ignored.
- irq_ret: clears the lowest-index set isr bit (highest priority in service). Ignored when isr == 0. irq_ret and irq_ack in the same cycle: both take effect (clear old bit, set new bit).
- Simultaneous set/clear on pend[i] (new edge in the same cycle as ack or pend_clr of i): the set wins; pend[i] remains 1.
- Mask writes take effect the cycle after mask_we. Masking does not clear pending bits.
- Bits of ports at index >= N_IRQ do not exist. All arithmetic wraps modulo 2^VEC_W.

Optional Feature:
- Macro: INTC_NESTING_EN.
- Defined: nesting per the eligibility rule above; up to N_IRQ channels may be in service at once.
- Undefined:
  - A channel is eligible only when isr == 0, so no nesting.
  - isr holds at most one bit.
  - irq_ret clears all of isr.

Test Plan:
- Reset, then irq_in[3] 0->1 with mask=8'hFF -> irq_req rises exactly SYNC_STAGES+1 edges after the first sampling; irq_vec=8'h1C; after irq_ack, pend_out=0 and isr_out=8'h08.
- irq_in[5] and irq_in[2] rise in the same cycle, mask=8'hFF -> first grant vec 8'h18. After ack and irq_ret, second grant vec 8'h24.
- With INTC_NESTING_EN: ch4 in service, ch1 edge -> request vec 8'h14 granted, isr=8'h12. Ch6 edge while isr=8'h12 -> no request until two irq_ret pulses. Without the macro, ch1 is not requested until irq_ret.
- mask=8'hFB, irq_in[2] edge -> pend_out=8'h04, irq_req stays 0. Then write mask=8'hFF -> request vec 8'h18.
- In REQ for ch3, assert pend_clr=8'h08 -> irq_req drops next cycle, isr unchanged. irq_ack in IDLE -> no state change.
- Assert reset while irq_req=1 and isr=8'h01 -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/int_ctrl_vec.sv
// Vectored interrupt controller: edge-latched pending, mask, fixed priority.
// Define INTC_NESTING_EN to let higher-priority channels preempt in service.
module int_ctrl_vec #(
    parameter int unsigned           N_IRQ       = 8,
    parameter int unsigned           VEC_W       = 8,
    parameter logic [VEC_W-1:0]      VEC_BASE    = 8'h10,
    parameter int unsigned           VEC_STRIDE  = 4,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_din,
    input  logic [N_IRQ-1:0] pend_clr,
    input  logic             irq_ack,
    input  logic             irq_ret,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    output logic [N_IRQ-1:0] pend_out,
    output logic [N_IRQ-1:0] isr_out,
    output logic [N_IRQ-1:0] mask_out
);

    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] rise;

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [IDX_W-1:0] chan_q, chan_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [N_IRQ-1:0] mask_q, mask_d;

    logic [N_IRQ-1:0] isr_lo, below, elig, win_oh;
    logic [N_IRQ-1:0] chan_oh, ack_clr, ret_clr;
    logic [IDX_W-1:0] win_idx;
    logic [VEC_W-1:0] vec_calc;
    logic             any_elig, ack_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    // Two's-complement trick isolates the lowest set bit.
    assign isr_lo = isr_q & (~isr_q + N_IRQ'(1));

`ifdef INTC_NESTING_EN
    assign below   = (isr_q == '0) ? '1 : (isr_lo - N_IRQ'(1));
    assign ret_clr = irq_ret ? isr_lo : '0;
`else
    assign below   = (isr_q == '0) ? '1 : '0;
    assign ret_clr = irq_ret ? isr_q : '0;
`endif

    assign elig     = pend_q & mask_q & below;
    assign win_oh   = elig & (~elig + N_IRQ'(1));
    assign any_elig = |elig;

    always_comb begin
        win_idx = '0;
        chan_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (win_oh[i]) win_idx = IDX_W'(i);
            chan_oh[i] = (chan_q == IDX_W'(i));
        end
    end

    assign vec_calc = VEC_W'(int'(VEC_BASE) + int'(win_idx) * int'(VEC_STRIDE));

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vec_d    = vec_q;
        chan_d   = chan_q;
        ack_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    chan_d  = win_idx;
                    vec_d   = vec_calc;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    ack_fire = 1'b1;
                    req_d    = 1'b0;
                    state_d  = IDLE;
                end else if (|(pend_clr & chan_oh)) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack_clr = ack_fire ? chan_oh : '0;
    // A fresh edge wins over any clear in the same cycle.
    assign pend_d  = (pend_q & ~pend_clr & ~ack_clr) | rise;
    assign isr_d   = (isr_q & ~ret_clr) | ack_clr;
    assign mask_d  = mask_we ? mask_din : mask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            vec_q   <= '0;
            chan_q  <= '0;
            pend_q  <= '0;
            isr_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            chan_q  <= chan_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            mask_q  <= mask_d;
        end
    end

    assign irq_req  = req_q;
    assign irq_vec  = vec_q;
    assign pend_out = pend_q;
    assign isr_out  = isr_q;
    assign mask_out = mask_q;

endmodule
